// File: rtl/intersection_pkg.sv
// Shared types and default timing for the intersection controller.
package intersection_pkg;

    typedef enum logic [2:0] {
        ALL_RED_B = 3'd0,
        NS_GREEN  = 3'd1,
        NS_ORANGE = 3'd2,
        ALL_RED_A = 3'd3,
        EW_GREEN  = 3'd4,
        EW_ORANGE = 3'd5,
        WALK_A    = 3'd6,
        WALK_B    = 3'd7
    } phase_e;

    localparam int GREEN_T_DEF  = 4;
    localparam int ORANGE_T_DEF = 2;
    localparam int ALLRED_T_DEF = 1;
    localparam int WALK_T_DEF   = 3;
    localparam int CW_DEF       = 4;

    typedef struct packed {
        logic red;
        logic orange;
        logic green;
    } light_t;

    localparam light_t LIGHT_RED    = '{red: 1'b1, orange: 1'b0, green: 1'b0};
    localparam light_t LIGHT_ORANGE = '{red: 1'b0, orange: 1'b1, green: 1'b0};
    localparam light_t LIGHT_GREEN  = '{red: 1'b0, orange: 1'b0, green: 1'b1};

    // Timer reload value for a duration; a zero duration behaves as one cycle.
    function automatic int dur_m1(int t);
        return (t < 1) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Pedestrian handshake and light-head bundle of the intersection controller.
interface intersection_controller_if;
    logic       ped_req;
    logic       ped_ack;
    logic       ns_red;
    logic       ns_orange;
    logic       ns_green;
    logic       ew_red;
    logic       ew_orange;
    logic       ew_green;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output ped_req,
        input  ped_ack, ns_red, ns_orange, ns_green,
        input  ew_red, ew_orange, ew_green, walk, phase
    );

    modport slave (
        input  ped_req,
        output ped_ack, ns_red, ns_orange, ns_green,
        output ew_red, ew_orange, ew_green, walk, phase
    );
endinterface

// File: rtl/phase_timer.sv
// Loadable phase down-counter that holds at zero; done flags a zero count.
module phase_timer #(
    parameter int             CW      = 4,
    parameter logic [CW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= RST_VAL;
        else       count_q <= count_d;
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-head intersection sequencer with all-red clearance phases.
// Pedestrian WALK insertion is present only when INTERSECTION_PED_EN is defined.
module intersection_controller
    import intersection_pkg::*;
#(
    parameter int GREEN_T  = GREEN_T_DEF,
    parameter int ORANGE_T = ORANGE_T_DEF,
    parameter int ALLRED_T = ALLRED_T_DEF,
    parameter int WALK_T   = WALK_T_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    intersection_controller_if.slave  bus
);

    localparam logic [CW-1:0] GREEN_M1  = CW'(dur_m1(GREEN_T));
    localparam logic [CW-1:0] ORANGE_M1 = CW'(dur_m1(ORANGE_T));
    localparam logic [CW-1:0] ALLRED_M1 = CW'(dur_m1(ALLRED_T));
    localparam logic [CW-1:0] WALK_M1   = CW'(dur_m1(WALK_T));

    phase_e        state_q, state_d;
    light_t        ns_q, ns_d, ew_q, ew_d;
    logic          timer_load, timer_done;
    logic [CW-1:0] timer_load_val;

`ifdef INTERSECTION_PED_EN
    logic ped_pending_q, ped_pending_d;
    logic walk_q, walk_d, ped_ack_q, ped_ack_d;
    logic in_walk, entering_walk;
`endif

    phase_timer #(.CW(CW), .RST_VAL(ALLRED_M1)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .done     (timer_done)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        if (timer_done) begin
            timer_load = 1'b1;
            case (state_q)
                ALL_RED_B: begin
                    state_d = NS_GREEN;
`ifdef INTERSECTION_PED_EN
                    if (ped_pending_q) state_d = WALK_B;
`endif
                end
                NS_GREEN:  state_d = NS_ORANGE;
                NS_ORANGE: state_d = ALL_RED_A;
                ALL_RED_A: begin
                    state_d = EW_GREEN;
`ifdef INTERSECTION_PED_EN
                    if (ped_pending_q) state_d = WALK_A;
`endif
                end
                EW_GREEN:  state_d = EW_ORANGE;
                EW_ORANGE: state_d = ALL_RED_B;
`ifdef INTERSECTION_PED_EN
                WALK_A:    state_d = EW_GREEN;
                WALK_B:    state_d = NS_GREEN;
`endif
                default:   state_d = ALL_RED_B;
            endcase
        end

        case (state_d)
            NS_GREEN, EW_GREEN:   timer_load_val = GREEN_M1;
            NS_ORANGE, EW_ORANGE: timer_load_val = ORANGE_M1;
            WALK_A, WALK_B:       timer_load_val = WALK_M1;
            default:              timer_load_val = ALLRED_M1;
        endcase

        // Lights follow the next state so the registered heads line up with phase.
        ns_d = LIGHT_RED;
        ew_d = LIGHT_RED;
        case (state_d)
            NS_GREEN:  ns_d = LIGHT_GREEN;
            NS_ORANGE: ns_d = LIGHT_ORANGE;
            EW_GREEN:  ew_d = LIGHT_GREEN;
            EW_ORANGE: ew_d = LIGHT_ORANGE;
            default:   ;
        endcase

`ifdef INTERSECTION_PED_EN
        in_walk       = (state_q == WALK_A) || (state_q == WALK_B);
        walk_d        = (state_d == WALK_A) || (state_d == WALK_B);
        entering_walk = walk_d && !in_walk;
        ped_ack_d     = entering_walk;
        // A request coinciding with WALK entry is served by that WALK.
        if (entering_walk)  ped_pending_d = 1'b0;
        else if (in_walk)   ped_pending_d = ped_pending_q;
        else                ped_pending_d = ped_pending_q | bus.ped_req;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ALL_RED_B;
            ns_q          <= LIGHT_RED;
            ew_q          <= LIGHT_RED;
`ifdef INTERSECTION_PED_EN
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
            ped_ack_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ns_q          <= ns_d;
            ew_q          <= ew_d;
`ifdef INTERSECTION_PED_EN
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
            ped_ack_q     <= ped_ack_d;
`endif
        end
    end

    assign bus.ns_red    = ns_q.red;
    assign bus.ns_orange = ns_q.orange;
    assign bus.ns_green  = ns_q.green;
    assign bus.ew_red    = ew_q.red;
    assign bus.ew_orange = ew_q.orange;
    assign bus.ew_green  = ew_q.green;
    assign bus.phase     = state_q;
`ifdef INTERSECTION_PED_EN
    assign bus.walk      = walk_q;
    assign bus.ped_ack   = ped_ack_q;
`else
    assign bus.walk      = 1'b0;
    assign bus.ped_ack   = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// Table-driven bench for intersection_controller with a scoreboard queue;
// expectations follow INTERSECTION_PED_EN when it is defined.
module tb_intersection_controller;
    import intersection_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    intersection_controller_if bus ();

    intersection_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic   rst;
        logic   req;
        phase_e ph;
        logic   ack;
    } vec_t;

    // {phase, walk, ack, ns rog, ew rog}
    typedef struct packed {
        logic [2:0] ph;
        logic       walk;
        logic       ack;
        logic [2:0] ns;
        logic [2:0] ew;
    } obs_t;

    vec_t tbl[$];
    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t model(input phase_e p, input logic ack);
        obs_t o;
        o.ph   = p;
        o.ack  = ack;
        o.walk = (p == WALK_A) || (p == WALK_B);
        o.ns   = 3'b100;
        o.ew   = 3'b100;
        if (p == NS_GREEN)  o.ns = 3'b001;
        if (p == NS_ORANGE) o.ns = 3'b010;
        if (p == EW_GREEN)  o.ew = 3'b001;
        if (p == EW_ORANGE) o.ew = 3'b010;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ph   = bus.phase;
        o.walk = bus.walk;
        o.ack  = bus.ped_ack;
        o.ns   = {bus.ns_red, bus.ns_orange, bus.ns_green};
        o.ew   = {bus.ew_red, bus.ew_orange, bus.ew_green};
        return o;
    endfunction

    task automatic add_run(input phase_e p, input int n);
        for (int i = 0; i < n; i++)
            tbl.push_back('{rst: 1'b0, req: 1'b0, ph: p,
                            ack: (i == 0) && (p == WALK_A || p == WALK_B)});
    endtask

    task automatic add_timeline();
        add_run(ALL_RED_B, 1); add_run(NS_GREEN, 4); add_run(NS_ORANGE, 2);
        add_run(ALL_RED_A, 1); add_run(EW_GREEN, 4); add_run(EW_ORANGE, 2);
    endtask

    // Leaves the bench at a falling edge in cycle 0 after reset release.
    task automatic do_reset();
        reset = 1'b1;
        bus.ped_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(sample()), 32'(model(ALL_RED_B, 1'b0)));
        reset = 1'b0;
    endtask

    task automatic run_table(input string name);
        obs_t exp;
        for (int i = 0; i < tbl.size(); i++) begin
            sb.push_back(model(tbl[i].ph, tbl[i].ack));
            exp = sb.pop_front();
            check($sformatf("%s[%0d]", name, i), 32'(sample()), 32'(exp));
            reset       = tbl[i].rst;
            bus.ped_req = tbl[i].req;
            @(posedge clk);
            @(negedge clk);
        end
        reset       = 1'b0;
        bus.ped_req = 1'b0;
        tbl.delete();
    endtask

    initial begin
        obs_t o;
        logic ns_nonred, ew_nonred;

        // Default timeline, no requests.
        do_reset();
        add_timeline(); add_run(ALL_RED_B, 1); add_run(NS_GREEN, 2);
        run_table("timeline");

        // Single request pulse at cycle 2.
        do_reset();
`ifdef INTERSECTION_PED_EN
        add_run(ALL_RED_B, 1); add_run(NS_GREEN, 4); add_run(NS_ORANGE, 2);
        add_run(ALL_RED_A, 1); add_run(WALK_A, 3); add_run(EW_GREEN, 4);
        add_run(EW_ORANGE, 2); add_run(ALL_RED_B, 1); add_run(NS_GREEN, 2);
`else
        add_timeline(); add_run(ALL_RED_B, 1); add_run(NS_GREEN, 2);
`endif
        tbl[2].req = 1'b1;
        run_table("ped_pulse");

        // Request held high throughout.
        do_reset();
`ifdef INTERSECTION_PED_EN
        add_run(ALL_RED_B, 1); add_run(NS_GREEN, 4); add_run(NS_ORANGE, 2);
        add_run(ALL_RED_A, 1); add_run(WALK_A, 3); add_run(EW_GREEN, 4);
        add_run(EW_ORANGE, 2); add_run(ALL_RED_B, 1); add_run(WALK_B, 3);
        add_run(NS_GREEN, 4); add_run(NS_ORANGE, 2); add_run(ALL_RED_A, 1);
        add_run(WALK_A, 3); add_run(EW_GREEN, 2);
`else
        add_timeline(); add_timeline(); add_run(ALL_RED_B, 1);
`endif
        for (int i = 0; i < tbl.size(); i++) tbl[i].req = 1'b1;
        run_table("ped_held");

        // Request pending in EW_GREEN, then a one-cycle reset: the pending
        // request must be dropped, so no WALK_B follows the restart.
        do_reset();
        add_run(ALL_RED_B, 1); add_run(NS_GREEN, 4); add_run(NS_ORANGE, 2);
        add_run(ALL_RED_A, 1); add_run(EW_GREEN, 4);
        add_timeline(); add_run(ALL_RED_B, 1); add_run(NS_GREEN, 1);
        tbl[9].req  = 1'b1;
        tbl[11].rst = 1'b1;
        run_table("mid_reset");

        // Random requests: safety invariants every cycle.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            o = sample();
            ns_nonred = !o.ns[2];
            ew_nonred = !o.ew[2];
            check("ns_onehot", 32'($onehot(o.ns)), 32'(1));
            check("ew_onehot", 32'($onehot(o.ew)), 32'(1));
            check("heads_conflict", 32'(ns_nonred && ew_nonred), 32'(0));
            check("walk_not_red", 32'(o.walk && (ns_nonred || ew_nonred)), 32'(0));
            check("ack_outside_walk", 32'(o.ack && !o.walk), 32'(0));
            bus.ped_req = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
        end
        bus.ped_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
